// File: rtl/regfile_access_arbiter_if.sv
// Requester, response and register-file signals shared by the arbiter and its environment.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface regfile_access_arbiter_if #(
  parameter int unsigned M = 4,
  parameter int unsigned W = 8
);
  // Requester A
  logic         a_req;
  logic         a_we;
  logic [M-1:0] a_waddr;
  logic [W-1:0] a_wdata;
  logic [M-1:0] a_raddr1;
  logic [M-1:0] a_raddr2;
  logic [M-1:0] a_raddr3;
  logic         a_gnt;
  logic         a_rvalid;
  // Requester B
  logic         b_req;
  logic         b_we;
  logic [M-1:0] b_waddr;
  logic [W-1:0] b_wdata;
  logic [M-1:0] b_raddr1;
  logic [M-1:0] b_raddr2;
  logic [M-1:0] b_raddr3;
  logic         b_gnt;
  logic         b_rvalid;
  // Shared response
  logic [W-1:0] rdata1;
  logic [W-1:0] rdata2;
  logic [W-1:0] rdata3;
  logic         err;
  logic         busy;
  // Register file port
  logic         rf_read_en;
  logic [M-1:0] rf_read_reg1;
  logic [M-1:0] rf_read_reg2;
  logic [M-1:0] rf_read_reg3;
  logic         rf_write_en;
  logic [M-1:0] rf_write_reg;
  logic [W-1:0] rf_write_data;
  logic [W-1:0] rf_read_data1;
  logic [W-1:0] rf_read_data2;
  logic [W-1:0] rf_read_data3;

  modport slave (
    input  a_req, a_we, a_waddr, a_wdata, a_raddr1, a_raddr2, a_raddr3,
    input  b_req, b_we, b_waddr, b_wdata, b_raddr1, b_raddr2, b_raddr3,
    input  rf_read_data1, rf_read_data2, rf_read_data3,
    output a_gnt, a_rvalid, b_gnt, b_rvalid,
    output rdata1, rdata2, rdata3, err, busy,
    output rf_read_en, rf_read_reg1, rf_read_reg2, rf_read_reg3,
    output rf_write_en, rf_write_reg, rf_write_data
  );

  modport master (
    output a_req, a_we, a_waddr, a_wdata, a_raddr1, a_raddr2, a_raddr3,
    output b_req, b_we, b_waddr, b_wdata, b_raddr1, b_raddr2, b_raddr3,
    output rf_read_data1, rf_read_data2, rf_read_data3,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid,
    input  rdata1, rdata2, rdata3, err, busy,
    input  rf_read_en, rf_read_reg1, rf_read_reg2, rf_read_reg3,
    input  rf_write_en, rf_write_reg, rf_write_data
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing one 3-read/1-write register file between requesters A and B.
// Each accepted transaction walks IDLE -> ISSUE -> CAPT -> RESP; out-of-range addresses
// are flagged and never reach the register file enables.
module regfile_access_arbiter #(
  parameter int unsigned M = 4,
  parameter int unsigned N = 15,
  parameter int unsigned W = 8
) (
  input logic                     clk,
  input logic                     rst,
  regfile_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapt, StResp} state_e;

  state_e       r_state;
  state_e       w_state_next;
  logic         r_last_grant;  // 1: B was granted last
  logic         r_win;         // 1: B owns the current transaction
  logic         r_we;
  logic         r_bad;
  logic [M-1:0] r_waddr;
  logic [M-1:0] r_raddr1;
  logic [M-1:0] r_raddr2;
  logic [M-1:0] r_raddr3;
  logic [W-1:0] r_wdata;
  logic [W-1:0] r_rdata1;
  logic [W-1:0] r_rdata2;
  logic [W-1:0] r_rdata3;
  logic         r_err;

  logic         w_any_req;
  logic         w_pick_b;
  logic         w_sel_we;
  logic         w_sel_bad;
  logic [M-1:0] w_sel_waddr;
  logic [M-1:0] w_sel_raddr1;
  logic [M-1:0] w_sel_raddr2;
  logic [M-1:0] w_sel_raddr3;
  logic [W-1:0] w_sel_wdata;

  function automatic logic addr_bad(input logic [M-1:0] addr);
    return 32'(addr) >= N;
  endfunction

  // Pick the winner and mux its command; on contention the side not granted last wins.
  always_comb begin
    w_any_req = bus.a_req | bus.b_req;
    w_pick_b  = (bus.a_req && bus.b_req) ? ~r_last_grant : bus.b_req;
    w_sel_we     = w_pick_b ? bus.b_we     : bus.a_we;
    w_sel_waddr  = w_pick_b ? bus.b_waddr  : bus.a_waddr;
    w_sel_wdata  = w_pick_b ? bus.b_wdata  : bus.a_wdata;
    w_sel_raddr1 = w_pick_b ? bus.b_raddr1 : bus.a_raddr1;
    w_sel_raddr2 = w_pick_b ? bus.b_raddr2 : bus.a_raddr2;
    w_sel_raddr3 = w_pick_b ? bus.b_raddr3 : bus.a_raddr3;
    w_sel_bad    = addr_bad(w_sel_raddr1) || addr_bad(w_sel_raddr2) ||
                   addr_bad(w_sel_raddr3) || (w_sel_we && addr_bad(w_sel_waddr));
  end

  // Next-state: fixed four-cycle walk once a request is accepted.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_any_req) w_state_next = StIssue;
      StIssue: w_state_next = StCapt;
      StCapt:  w_state_next = StResp;
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State, command capture in IDLE and response capture in CAPT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_win        <= 1'b0;
      r_we         <= 1'b0;
      r_bad        <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_raddr1     <= '0;
      r_raddr2     <= '0;
      r_raddr3     <= '0;
      r_rdata1     <= '0;
      r_rdata2     <= '0;
      r_rdata3     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && w_any_req) begin
        r_last_grant <= w_pick_b;
        r_win        <= w_pick_b;
        r_we         <= w_sel_we;
        r_bad        <= w_sel_bad;
        r_waddr      <= w_sel_waddr;
        r_wdata      <= w_sel_wdata;
        r_raddr1     <= w_sel_raddr1;
        r_raddr2     <= w_sel_raddr2;
        r_raddr3     <= w_sel_raddr3;
      end
      if (r_state == StCapt) begin
        r_rdata1 <= r_bad ? '0 : bus.rf_read_data1;
        r_rdata2 <= r_bad ? '0 : bus.rf_read_data2;
        r_rdata3 <= r_bad ? '0 : bus.rf_read_data3;
        r_err    <= r_bad;
      end
    end
  end

  // Outputs; rf addresses come straight from the capture registers so they hold between
  // transactions, and the enables are gated by rst so a reset edge never writes.
  always_comb begin
    bus.a_gnt         = (r_state == StIssue) && !r_win;
    bus.b_gnt         = (r_state == StIssue) &&  r_win;
    bus.a_rvalid      = (r_state == StResp)  && !r_win;
    bus.b_rvalid      = (r_state == StResp)  &&  r_win;
    bus.busy          = (r_state != StIdle);
    bus.rdata1        = r_rdata1;
    bus.rdata2        = r_rdata2;
    bus.rdata3        = r_rdata3;
    bus.err           = r_err;
    bus.rf_read_en    = (r_state == StIssue) && !r_bad && !rst;
    bus.rf_write_en   = (r_state == StIssue) && !r_bad && r_we && !rst;
    bus.rf_read_reg1  = r_raddr1;
    bus.rf_read_reg2  = r_raddr2;
    bus.rf_read_reg3  = r_raddr3;
    bus.rf_write_reg  = r_waddr;
    bus.rf_write_data = r_wdata;
  end

endmodule
